unary_accum_n: RTL

Parametrised unary accumulator for the unary arithmetic datapath. Each cycle in read mode it sums the number of asserted pulses across `NCH` unary input channels into a modulo‑(`MAX`+1) counter, or into a saturating counter when so configured, and flags wrap‑around. In write mode it serialises the held count back out as a unary pulse train on `dout`, with completion signalled on `done`. It is the multi‑channel, mode‑configurable successor of the two‑input 0..16 unary adder.

---
 rtl/unary_pkg.sv | 12 +
 rtl/unary_popcount.sv | 18 +
 rtl/unary_accum_n.sv | 97 +++++++++
 3 files changed

// File: rtl/unary_pkg.sv
// Shared definitions for the unary arithmetic datapath: counter width helper
// and the read_or_write mode encodings.
package unary_pkg;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    function automatic int cw_of(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/unary_popcount.sv
// Combinational population count of NCH unary pulse inputs.
module unary_popcount #(
    parameter  int NCH = 4,
    localparam int PW  = $clog2(NCH + 1)
) (
    input  logic [NCH-1:0] din,
    output logic [PW-1:0]  cnt
);

    always_comb begin
        // NOTE: blocking assignments in always_comb; the default-first pattern keeps it latch-free.
        cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt = cnt + PW'(din[i]);
        end
    end

endmodule

// File: rtl/unary_accum_n.sv
// Multi-channel unary accumulator: sums input pulses into a wrapping or
// saturating counter, then drains the count back out as a unary pulse train.
module unary_accum_n
    import unary_pkg::*;
#(
    parameter  int NCH  = 4,
    parameter  int MAX  = 16,
    parameter  bit WRAP = 1'b1,
    localparam int CW   = cw_of(MAX)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           read_or_write,
    input  logic [NCH-1:0] din,
    output logic           dout,
    output logic           C,
    output logic           ovf,
    output logic           done,
    output logic [CW-1:0]  level
);

    localparam int PW = $clog2(NCH + 1);
    localparam int SW = CW + 1;

    localparam logic [SW-1:0] MAX_S = SW'(MAX);
    localparam logic [SW-1:0] MOD_S = SW'(MAX + 1);
    localparam logic [CW-1:0] MAX_L = CW'(MAX);
    localparam logic [CW-1:0] ONE_L = CW'(1);

    logic [PW-1:0] pop;
    logic [SW-1:0] sum;

    logic [CW-1:0] level_d;
    logic          dout_d;
    logic          c_d;
    logic          ovf_d;
    logic          done_d;

    unary_popcount #(.NCH(NCH)) u_popcount (
        .din (din),
        .cnt (pop)
    );

    // One extra bit holds level + pop without loss, since NCH <= MAX.
    assign sum = {1'b0, level} + SW'(pop);

    always_comb begin
        level_d = level;
        ovf_d   = ovf;
        dout_d  = 1'b0;
        c_d     = 1'b0;
        done_d  = 1'b0;

        if (en) begin
            if (read_or_write == RD) begin
                if (sum > MAX_S) begin
                    if (WRAP) begin
                        level_d = CW'(sum - MOD_S);
                        c_d     = 1'b1;
                    end else begin
                        level_d = MAX_L;
                        ovf_d   = 1'b1;
                    end
                end else begin
                    level_d = sum[CW-1:0];
                end
            end else if (level != '0) begin
                dout_d  = 1'b1;
                level_d = level - ONE_L;
                // Emitting the last pulse ends the drain and releases overflow.
                if (level == ONE_L) begin
                    done_d = 1'b1;
                    ovf_d  = 1'b0;
                end
            end
        end
    end

    // NOTE: synchronous reset lives inside the clocked block and uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level <= '0;
            dout  <= 1'b0;
            C     <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            level <= level_d;
            dout  <= dout_d;
            C     <= c_d;
            ovf   <= ovf_d;
            done  <= done_d;
        end
    end

endmodule
